// File: rtl/def_pkg.sv
// Shared definitions: exception record, extension-context state encoding and cause codes.
package def_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef enum logic [1:0] {
    CTX_OFF     = 2'd0,
    CTX_INITIAL = 2'd1,
    CTX_CLEAN   = 2'd2,
    CTX_DIRTY   = 2'd3
  } ctx_state_t;

  localparam logic [63:0] EXC_ILLEGAL_INSTR = 64'd2;

endpackage

// File: rtl/ext_ctx_fsm.sv
// One extension context: state register, CSR/commit next-state logic and the
// optional dirty-transition counter (built only when EXT_CTX_PERF_EN is defined).
module ext_ctx_fsm
  import def_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 csr_we,
  input  logic [1:0]           csr_wdata,
  input  logic                 commit_mark,
  output ctx_state_t           state,
  output logic [CNT_WIDTH-1:0] dirty_cnt
);

  ctx_state_t state_q;
  ctx_state_t state_d;

  // CSR write applies first; a commit mark can only dirty a context that is not Off afterwards.
  always_comb begin
    state_d = state_q;
    if (csr_we) state_d = ctx_state_t'(csr_wdata);
    if (commit_mark && (state_d != CTX_OFF)) state_d = CTX_DIRTY;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= CTX_OFF;
    else       state_q <= state_d;
  end

  assign state = state_q;

`ifdef EXT_CTX_PERF_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if ((state_q != CTX_DIRTY) && (state_d == CTX_DIRTY) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign dirty_cnt = cnt_q;
`else
  assign dirty_cnt = '0;
`endif

endmodule

// File: rtl/ext_ctx_status.sv
// Extension-context status tracker (FS/VS/XS style) with Off-use exception capture
// and SD/XS summaries. Optional per-context dirty counters: EXT_CTX_PERF_EN.
module ext_ctx_status
  import def_pkg::*;
#(
  parameter int NUM_CTX      = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   csr_we_i,
  input  logic [NUM_CTX-1:0]                     csr_wmask_i,
  input  logic [2*NUM_CTX-1:0]                   csr_wdata_i,
  input  logic [COMMIT_WIDTH-1:0]                commit_valid_i,
  input  logic [COMMIT_WIDTH-1:0][NUM_CTX-1:0]   commit_ctx_i,
  input  logic                                   use_valid_i,
  input  logic [NUM_CTX-1:0]                     use_ctx_i,
  input  logic [63:0]                            use_tval_i,
  input  logic                                   flush_i,
  input  logic                                   exc_ack_i,
  output exception_t                             exc_o,
  output logic [NUM_CTX-1:0][1:0]                ctx_state_o,
  output logic                                   sd_o,
  output logic [1:0]                             xs_o,
  output logic [NUM_CTX-1:0][CNT_WIDTH-1:0]      perf_dirty_cnt_o
);

  logic [NUM_CTX-1:0] commit_mark;
  logic [NUM_CTX-1:0] off_vec;
  logic               trigger;
  exception_t         exc_q;

  always_comb begin
    commit_mark = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        commit_mark[i] = commit_mark[i] | (commit_valid_i[l] & commit_ctx_i[l][i]);
      end
    end
  end

  for (genvar i = 0; i < NUM_CTX; i++) begin : g_ctx
    ctx_state_t state;

    ext_ctx_fsm #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ctx (
      .clk         (clk_i),
      .rstn        (rstn_i),
      .csr_we      (csr_we_i & csr_wmask_i[i]),
      .csr_wdata   (csr_wdata_i[2*i +: 2]),
      .commit_mark (commit_mark[i]),
      .state       (state),
      .dirty_cnt   (perf_dirty_cnt_o[i])
    );

    assign ctx_state_o[i] = state;
    assign off_vec[i]     = (state == CTX_OFF);
  end

  always_comb begin
    sd_o = 1'b0;
    xs_o = 2'd0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (ctx_state_o[i] == 2'(CTX_DIRTY)) sd_o = 1'b1;
      if (ctx_state_o[i] > xs_o)           xs_o = ctx_state_o[i];
    end
  end

  // Use checks look only at registered state, so a same-cycle CSR write cannot mask them.
  assign trigger = use_valid_i & (|(use_ctx_i & off_vec));

  // Flush beats ack beats capture; a pending exception blocks any new capture.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exc_q <= '0;
    end else if (flush_i) begin
      exc_q <= '0;
    end else if (exc_q.valid) begin
      if (exc_ack_i) exc_q <= '0;
    end else if (trigger) begin
      exc_q.valid <= 1'b1;
      exc_q.cause <= EXC_ILLEGAL_INSTR;
      exc_q.tval  <= use_tval_i;
    end
  end

  assign exc_o = exc_q;

endmodule

// File: tb/tb_ext_ctx_status.sv
// Bench for ext_ctx_status: directed vector table, multi-cycle corner sequences and
// random traffic checked against a behavioural model of the context/exception rules.
module tb_ext_ctx_status;
  import def_pkg::*;

  localparam int NC = 2;
  localparam int CW = 2;
  localparam int CL = 2;

  logic                 clk = 1'b0;
  logic                 rstn_i;
  logic                 csr_we_i;
  logic [NC-1:0]        csr_wmask_i;
  logic [2*NC-1:0]      csr_wdata_i;
  logic [CL-1:0]        commit_valid_i;
  logic [CL-1:0][NC-1:0] commit_ctx_i;
  logic                 use_valid_i;
  logic [NC-1:0]        use_ctx_i;
  logic [63:0]          use_tval_i;
  logic                 flush_i;
  logic                 exc_ack_i;
  exception_t           exc_o;
  logic [NC-1:0][1:0]   ctx_state_o;
  logic                 sd_o;
  logic [1:0]           xs_o;
  logic [NC-1:0][CW-1:0] perf_dirty_cnt_o;

  ext_ctx_status #(.NUM_CTX(NC), .COMMIT_WIDTH(CL), .CNT_WIDTH(CW)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn_i),
    .csr_we_i         (csr_we_i),
    .csr_wmask_i      (csr_wmask_i),
    .csr_wdata_i      (csr_wdata_i),
    .commit_valid_i   (commit_valid_i),
    .commit_ctx_i     (commit_ctx_i),
    .use_valid_i      (use_valid_i),
    .use_ctx_i        (use_ctx_i),
    .use_tval_i       (use_tval_i),
    .flush_i          (flush_i),
    .exc_ack_i        (exc_ack_i),
    .exc_o            (exc_o),
    .ctx_state_o      (ctx_state_o),
    .sd_o             (sd_o),
    .xs_o             (xs_o),
    .perf_dirty_cnt_o (perf_dirty_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model
  int          m_st [NC];
  int          m_cnt[NC];
  bit          m_valid;
  logic [63:0] m_tval;

`ifdef EXT_CTX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  wmask;
    logic [3:0]  wdata;
    logic [1:0]  cvalid;
    logic [3:0]  cctx;     // {lane1, lane0}
    logic        uvalid;
    logic [1:0]  uctx;
    logic [63:0] tval;
    logic        flush;
    logic        ack;
    logic [3:0]  exp_state; // {ctx1, ctx0}
    logic        exp_sd;
    logic [1:0]  exp_xs;
    logic        exp_valid;
    logic [63:0] exp_tval;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    csr_we_i = 0; csr_wmask_i = '0; csr_wdata_i = '0;
    commit_valid_i = '0; commit_ctx_i = '0;
    use_valid_i = 0; use_ctx_i = '0; use_tval_i = '0;
    flush_i = 0; exc_ack_i = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin m_st[i] = 0; m_cnt[i] = 0; end
    m_valid = 0; m_tval = '0;
  endtask

  task automatic compare_model();
    int max_s;
    bit any_d;
    max_s = 0; any_d = 0;
    for (int i = 0; i < NC; i++) begin
      check($sformatf("state%0d", i), 64'(ctx_state_o[i]), 64'(m_st[i]));
      check($sformatf("cnt%0d", i), 64'(perf_dirty_cnt_o[i]), PERF ? 64'(m_cnt[i]) : 64'd0);
      if (m_st[i] == 3) any_d = 1;
      if (m_st[i] > max_s) max_s = m_st[i];
    end
    check("sd", 64'(sd_o), 64'(any_d));
    check("xs", 64'(xs_o), 64'(max_s));
    check("exc_valid", 64'(exc_o.valid), 64'(m_valid));
    if (m_valid) begin
      check("exc_cause", exc_o.cause, 64'd2);
      check("exc_tval", exc_o.tval, m_tval);
    end
  endtask

  // One clock: model predicts from current inputs, then DUT is sampled 1 time unit after the edge.
  task automatic step();
    int  nxt[NC];
    bit  trig;
    int  cmax;
    cmax = (1 << CW) - 1;
    trig = 0;
    for (int i = 0; i < NC; i++)
      if (use_valid_i && use_ctx_i[i] && m_st[i] == 0) trig = 1;
    for (int i = 0; i < NC; i++) begin
      bit marked;
      nxt[i] = m_st[i];
      if (csr_we_i && csr_wmask_i[i]) nxt[i] = int'(csr_wdata_i[2*i +: 2]);
      marked = 0;
      for (int l = 0; l < CL; l++) if (commit_valid_i[l] && commit_ctx_i[l][i]) marked = 1;
      if (marked && nxt[i] != 0) nxt[i] = 3;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (m_st[i] != 3 && nxt[i] == 3 && m_cnt[i] < cmax) m_cnt[i]++;
      m_st[i] = nxt[i];
    end
    if (flush_i) m_valid = 0;
    else if (m_valid) begin if (exc_ack_i) m_valid = 0; end
    else if (trig) begin m_valid = 1; m_tval = use_tval_i; end
    compare_model();
  endtask

  vec_t vecs[12];

  initial begin
    logic [CW-1:0] exp_sat;
    //         we wmask wdata   cval  cctx     uv uctx tval        fl ak  state    sd xs  v  tval
    vecs[0]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 1, 2'b01, 64'h12345, 0, 0, 4'b0000, 0, 0, 1, 64'h12345};
    vecs[1]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 0, 2'b00, 64'h0,     0, 0, 4'b0000, 0, 0, 1, 64'h12345};
    vecs[2]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 1, 2'b10, 64'hAAA,   0, 0, 4'b0000, 0, 0, 1, 64'h12345};
    vecs[3]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 0, 2'b00, 64'h0,     0, 1, 4'b0000, 0, 0, 0, 64'h0};
    vecs[4]  = '{1, 2'b11, 4'b1001, 2'b00, 4'h0, 0, 2'b00, 64'h0,  0, 0, 4'b1001, 0, 2, 0, 64'h0};
    vecs[5]  = '{0, 2'b00, 4'h0, 2'b10, 4'b0100, 0, 2'b00, 64'h0,  0, 0, 4'b1011, 1, 3, 0, 64'h0};
    vecs[6]  = '{1, 2'b01, 4'h0, 2'b01, 4'b0001, 0, 2'b00, 64'h0,  0, 0, 4'b1000, 0, 2, 0, 64'h0};
    vecs[7]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 1, 2'b01, 64'h55,    0, 0, 4'b1000, 0, 2, 1, 64'h55};
    vecs[8]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 1, 2'b01, 64'h66,    1, 0, 4'b1000, 0, 2, 0, 64'h0};
    vecs[9]  = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 0, 2'b00, 64'h0,     0, 0, 4'b1000, 0, 2, 0, 64'h0};
    vecs[10] = '{1, 2'b01, 4'b0001, 2'b00, 4'h0, 1, 2'b01, 64'h77, 0, 0, 4'b1001, 0, 2, 1, 64'h77};
    vecs[11] = '{0, 2'b00, 4'h0, 2'b00, 4'h0, 0, 2'b00, 64'h0,     0, 1, 4'b1001, 0, 2, 0, 64'h0};

    idle();
    rstn_i = 0;
    model_reset();
    #12;
    check("rst_state", 64'(ctx_state_o), 64'd0);
    check("rst_exc", 64'(exc_o.valid) | exc_o.cause | exc_o.tval, 64'd0);
    check("rst_sd_xs", {61'd0, sd_o, xs_o}, 64'd0);
    check("rst_cnt", 64'(perf_dirty_cnt_o), 64'd0);
    @(negedge clk);
    rstn_i = 1;
    #1;

    for (int v = 0; v < 12; v++) begin
      csr_we_i = vecs[v].we; csr_wmask_i = vecs[v].wmask; csr_wdata_i = vecs[v].wdata;
      commit_valid_i = vecs[v].cvalid; commit_ctx_i = vecs[v].cctx;
      use_valid_i = vecs[v].uvalid; use_ctx_i = vecs[v].uctx; use_tval_i = vecs[v].tval;
      flush_i = vecs[v].flush; exc_ack_i = vecs[v].ack;
      step();
      check($sformatf("vec%0d_state", v), 64'(ctx_state_o), 64'(vecs[v].exp_state));
      check($sformatf("vec%0d_sd", v), 64'(sd_o), 64'(vecs[v].exp_sd));
      check($sformatf("vec%0d_xs", v), 64'(xs_o), 64'(vecs[v].exp_xs));
      check($sformatf("vec%0d_valid", v), 64'(exc_o.valid), 64'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) check($sformatf("vec%0d_tval", v), exc_o.tval, vecs[v].exp_tval);
    end

    // ctx1 Clean -> Dirty five times; counter must stop at all-ones
    for (int k = 0; k < 5; k++) begin
      idle(); commit_valid_i = 2'b01; commit_ctx_i = 4'b0010;
      step();
      idle(); csr_we_i = 1; csr_wmask_i = 2'b10; csr_wdata_i = 4'b1000;
      step();
    end
    exp_sat = PERF ? '1 : '0;
    check("perf_sat_ctx1", 64'(perf_dirty_cnt_o[1]), 64'(exp_sat));

    // ctx0 Dirty, ctx1 Off, then an exception on ctx1, then async reset between edges
    idle(); csr_we_i = 1; csr_wmask_i = 2'b11; csr_wdata_i = 4'b0010;
    commit_valid_i = 2'b01; commit_ctx_i = 4'b0001;
    step();
    idle(); use_valid_i = 1; use_ctx_i = 2'b10; use_tval_i = 64'hBEEF;
    step();
    check("pre_rst_pending", 64'(exc_o.valid), 64'd1);
    check("pre_rst_ctx0", 64'(ctx_state_o[0]), 64'd3);
    idle();
    #2;
    rstn_i = 0;
    #1;
    model_reset();
    check("async_rst_state", 64'(ctx_state_o), 64'd0);
    check("async_rst_exc", 64'(exc_o.valid) | exc_o.cause | exc_o.tval, 64'd0);
    check("async_rst_sd_xs", {61'd0, sd_o, xs_o}, 64'd0);
    check("async_rst_cnt", 64'(perf_dirty_cnt_o), 64'd0);
    @(negedge clk);
    rstn_i = 1;
    #1;

    for (int c = 0; c < 400; c++) begin
      csr_we_i       = ($urandom_range(0, 3) == 0);
      csr_wmask_i    = NC'($urandom);
      csr_wdata_i    = (2*NC)'($urandom);
      commit_valid_i = CL'($urandom);
      commit_ctx_i   = (CL*NC)'($urandom);
      use_valid_i    = ($urandom_range(0, 1) == 1);
      use_ctx_i      = NC'($urandom);
      use_tval_i     = {$urandom, $urandom};
      flush_i        = ($urandom_range(0, 7) == 0);
      exc_ack_i      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
